pp_write_sequencer: RTL and testbench

PP_WRITE_SEQUENCER -- requirements
Module: pp_write_sequencer

---
 rtl/pp_write_sequencer_pkg.sv | 12 +
 rtl/top_pkg.sv | 4 +
 rtl/pp_write_sequencer_if.sv | 36 +++
 rtl/pp_write_sequencer.sv | 158 +++++++++++++++
 tb/tb_pp_write_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pp_write_sequencer_pkg.sv
// Width helpers shared by the write sequencer and its interface so both derive identical bus sizes.
package pp_write_sequencer_pkg;

  function automatic int module_width(input int width, input int cores_a, input int cores_b);
    return width * top_pkg::TOP_CHUNK_SIZE * cores_a * cores_b;
  endfunction

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/top_pkg.sv
// Project-wide constants shared by the datapath blocks.
package top_pkg;
  localparam int TOP_CHUNK_SIZE = 1;
endpackage

// File: rtl/pp_write_sequencer_if.sv
// Producer handshake plus ping-pong bank write port of the write sequencer.
interface pp_write_sequencer_if
  import pp_write_sequencer_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int NUM_CORES_A   = 2,
  parameter int NUM_CORES_B   = 1,
  parameter int TOTAL_MODULES = 4,
  parameter int COL_X         = 16,
  parameter int TOTAL_INPUT_W = 2
);
  localparam int TOTAL_DEPTH  = COL_X * TOTAL_INPUT_W;
  localparam int MODULE_WIDTH = module_width(WIDTH, NUM_CORES_A, NUM_CORES_B);
  localparam int IN_WIDTH     = MODULE_WIDTH * TOTAL_MODULES;
  localparam int ADDR_WIDTH   = index_width(TOTAL_DEPTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [IN_WIDTH-1:0]     in_data;
  logic                    bank_free;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [MODULE_WIDTH-1:0] wr_data;
  logic                    bank_done;
  logic                    flush;

  modport master (
    output in_valid, in_data, bank_free, flush,
    input  in_ready, wr_en, wr_addr, wr_data, bank_done
  );

  modport slave (
    input  in_valid, in_data, bank_free, flush,
    output in_ready, wr_en, wr_addr, wr_data, bank_done
  );
endinterface

// File: rtl/pp_write_sequencer.sv
// Splits each wide projection word into TOTAL_MODULES bank writes, slice 0 first, filling one ping-pong bank.
// First write the cycle after the handshake; in_ready only when idle-accepting or on a last slice with room left.
module pp_write_sequencer
  import pp_write_sequencer_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int NUM_CORES_A   = 2,
  parameter int NUM_CORES_B   = 1,
  parameter int TOTAL_MODULES = 4,
  parameter int COL_X         = 16,
  parameter int TOTAL_INPUT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pp_write_sequencer_if.slave  bus
);
  localparam int TOTAL_DEPTH  = COL_X * TOTAL_INPUT_W;
  localparam int MODULE_WIDTH = module_width(WIDTH, NUM_CORES_A, NUM_CORES_B);
  localparam int ADDR_WIDTH   = index_width(TOTAL_DEPTH);
  localparam int SLICE_WIDTH  = index_width(TOTAL_MODULES);

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(TOTAL_DEPTH - 1);
  localparam logic [SLICE_WIDTH-1:0] LAST_SLICE = SLICE_WIDTH'(TOTAL_MODULES - 1);

  localparam logic [1:0] WAIT_BANK = 2'd0;
  localparam logic [1:0] ACCEPT    = 2'd1;
  localparam logic [1:0] SERIALIZE = 2'd2;

  if (TOTAL_DEPTH % TOTAL_MODULES != 0) begin : g_depth_check
    $error("TOTAL_DEPTH must be a whole number of input words");
  end

  logic [1:0]              state_q, state_d;
  logic [SLICE_WIDTH-1:0]  slice_q, slice_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [MODULE_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                    bank_done_q, bank_done_d;
  logic [MODULE_WIDTH-1:0] latch_q  [TOTAL_MODULES];
  logic [MODULE_WIDTH-1:0] in_slice [TOTAL_MODULES];
  logic                    hs, load, advance, start, wr_go;

  assign hs = bus.in_valid & in_ready_q;

  always_comb begin
    for (int k = 0; k < TOTAL_MODULES; k++) begin
      in_slice[k] = bus.in_data[k*MODULE_WIDTH +: MODULE_WIDTH];
    end
  end

  // slice_q is the slice on the write port this cycle; cnt_q is the next bank address.
  always_comb begin
    state_d     = state_q;
    slice_d     = slice_q;
    cnt_d       = cnt_q;
    in_ready_d  = 1'b0;
    wr_data_d   = '0;
    bank_done_d = 1'b0;
    load        = 1'b0;
    advance     = 1'b0;
    start       = 1'b0;

    case (state_q)
      WAIT_BANK: begin
        if (bus.bank_free) begin
          state_d    = ACCEPT;
          in_ready_d = 1'b1;
        end
      end
      ACCEPT: begin
        if (hs) begin
          load  = 1'b1;
          start = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      SERIALIZE: begin
        if (slice_q != LAST_SLICE) begin
          advance = 1'b1;
        end else if (hs) begin
          load  = 1'b1;
          start = 1'b1;
        end else if (bank_done_q) begin
          state_d = WAIT_BANK;
        end else begin
          state_d    = ACCEPT;
          in_ready_d = 1'b1;
        end
      end
      default: state_d = WAIT_BANK;
    endcase

    // Ready is offered on the last slice so the next word follows without a bubble.
    if (advance || start) begin
      slice_d     = start ? '0 : slice_q + 1'b1;
      wr_data_d   = start ? in_slice[0] : latch_q[slice_d];
      state_d     = SERIALIZE;
      bank_done_d = (cnt_q == LAST_ADDR);
      cnt_d       = bank_done_d ? '0 : cnt_q + 1'b1;
      in_ready_d  = (slice_d == LAST_SLICE) && !bank_done_d;
    end

    if (bus.flush) begin
      state_d     = WAIT_BANK;
      slice_d     = '0;
      cnt_d       = '0;
      in_ready_d  = 1'b0;
      bank_done_d = 1'b0;
      load        = 1'b0;
      advance     = 1'b0;
      start       = 1'b0;
    end
  end

  assign wr_go = advance | start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_BANK;
      slice_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      bank_done_q <= 1'b0;
      for (int k = 0; k < TOTAL_MODULES; k++) begin
        latch_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      slice_q     <= slice_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_go;
      bank_done_q <= bank_done_d;
      if (wr_go) begin
        wr_addr_q <= cnt_q;
        wr_data_q <= wr_data_d;
      end
      if (load) begin
        for (int k = 0; k < TOTAL_MODULES; k++) begin
          latch_q[k] <= in_slice[k];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.bank_done = bank_done_q;

endmodule

// File: tb/tb_pp_write_sequencer.sv
// Scoreboard bench: each accepted word queues its expected bank writes; a negedge monitor checks them.
module tb_pp_write_sequencer;
  localparam int MW    = 16 * top_pkg::TOP_CHUNK_SIZE * 2 * 1;
  localparam int NM    = 4;
  localparam int DEPTH = 32;

  typedef struct {
    int          addr;
    logic [MW-1:0] data;
    bit          last;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst_n;
  int total = 0, bad = 0, cyc = 0;
  int model_addr = 0, rdy_cnt = 0, accepted = 0;
  int wr_count = 0, first_wr = -1, last_wr = -1;
  bit pattern = 1'b1;

  pp_write_sequencer_if bus ();
  pp_write_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.wr_en === 1'b1) begin
      wr_count++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got write at addr %0d expected none", bus.wr_addr);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
        check("wr_data", 64'(bus.wr_data), 64'(e.data));
        check("bank_done", 64'(bus.bank_done), 64'(e.last));
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      check("idle_bank_done", 64'(bus.bank_done), 64'd0);
    end
  end

  // Called at posedge+1; drives the word offered this cycle.
  task automatic drive(input bit v);
    bus.in_valid = v;
    for (int k = 0; k < NM; k++) begin
      bus.in_data[k*MW +: MW] = pattern ? MW'(model_addr + k) : MW'($urandom);
    end
  endtask

  // Decides what the coming edge does, from the inputs and the visible in_ready.
  task automatic eval_cycle();
    exp_t e;
    @(negedge clk);
    #1;
    if (bus.in_ready === 1'b1) rdy_cnt++;
    if (bus.flush) begin
      sb.delete();
      model_addr = 0;
    end else if (bus.in_valid && bus.in_ready === 1'b1) begin
      for (int k = 0; k < NM; k++) begin
        e.addr = model_addr;
        e.data = bus.in_data[k*MW +: MW];
        e.last = (model_addr == DEPTH - 1);
        e.cyc  = cyc + 1 + k;
        sb.push_back(e);
        model_addr = (model_addr + 1) % DEPTH;
      end
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_words(input int n, input int pct, input int budget);
    int got, c, a0;
    got = 0;
    c = 0;
    while (got < n && c < budget) begin
      a0 = accepted;
      drive($urandom_range(99) < pct);
      eval_cycle();
      got += accepted - a0;
      c++;
    end
    bus.in_valid = 1'b0;
    check("words_accepted", 64'(got), 64'(n));
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (sb.size() > 0 && c < budget) begin
      drive(1'b0);
      eval_cycle();
      c++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_addr(input int a, input int budget);
    int c;
    c = 0;
    while (!(bus.wr_en === 1'b1 && int'(bus.wr_addr) == a) && c < budget) begin
      drive(1'b0);
      eval_cycle();
      c++;
    end
    check("reached_addr", 64'(bus.wr_en === 1'b1 && int'(bus.wr_addr) == a), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
    check({tag, "_bank_done"}, 64'(bus.bank_done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.bank_free = 1'b0;
    bus.flush = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_outputs_zero("post_reset");

    // Bank not free: in_valid ignored, nothing written.
    rdy_cnt = 0;
    repeat (5) begin
      drive(1'b1);
      eval_cycle();
    end
    check("ready_while_not_free", 64'(rdy_cnt), 64'd0);

    // Full bank with in_valid held high; bank_free drops mid-bank without stalling.
    bus.bank_free = 1'b1;
    rdy_cnt = 0;
    wr_count = 0;
    first_wr = -1;
    last_wr = -1;
    run_words(1, 100, 10);
    bus.bank_free = 1'b0;
    run_words(7, 100, 40);
    drain(10);
    check("bank_writes", 64'(wr_count), 64'd32);
    check("bank_write_span", 64'(last_wr - first_wr), 64'd31);
    check("ready_pulses", 64'(rdy_cnt), 64'd8);

    // After bank_done with no free bank: stays idle.
    repeat (10) begin
      drive(1'b1);
      eval_cycle();
    end
    check("idle_ready_pulses", 64'(rdy_cnt), 64'd8);
    check("idle_writes", 64'(wr_count), 64'd32);

    // Next bank from addr 0; flush during slice 2 of word 3.
    bus.bank_free = 1'b1;
    run_words(4, 100, 30);
    wait_addr(3 * NM + 2, 10);
    bus.flush = 1'b1;
    drive(1'b1);
    eval_cycle();
    bus.flush = 1'b0;
    check("flush_wr_en", 64'(bus.wr_en), 64'd0);
    check("flush_bank_done", 64'(bus.bank_done), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);

    // Flush beats a simultaneous handshake.
    c = 0;
    while (bus.in_ready !== 1'b1 && c < 10) begin
      drive(1'b0);
      eval_cycle();
      c++;
    end
    check("ready_after_flush", 64'(bus.in_ready), 64'd1);
    bus.flush = 1'b1;
    drive(1'b1);
    eval_cycle();
    bus.flush = 1'b0;
    check("flush_drops_word", 64'(bus.wr_en), 64'd0);

    // Random in_valid: same address/data sequence, gaps only between words.
    run_words(8, 40, 400);
    drain(10);

    // Reset during word 5 slice 1.
    run_words(6, 100, 40);
    wait_addr(5 * NM + 1, 10);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    sb.delete();
    model_addr = 0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    pattern = 1'b0;
    run_words(8, 70, 200);
    drain(10);

    // Random soak: bank_free, in_valid and occasional flush.
    for (int i = 0; i < 300; i++) begin
      bus.bank_free = ($urandom_range(3) != 0);
      bus.flush = ($urandom_range(49) == 0);
      drive($urandom_range(1) == 1);
      eval_cycle();
    end
    bus.flush = 1'b0;
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
